// File: rtl/fft_ctrl_pkg.sv
// Shared FFT tile-loader control types: FSM states and width derivation helpers.
package fft_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2
  } state_e;

  function automatic int cmplx_len(input int datalen);
    return 2 * datalen;
  endfunction

  function automatic int beat_smp(input int axiwid, input int datalen);
    return axiwid / (2 * datalen);
  endfunction

  // Counter width that never collapses to zero bits.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fft_tile_buf.sv
// One tile of complex samples: BEATSMP-lane beat write port, FFTCHNL-lane combinational read port.
module fft_tile_buf import fft_ctrl_pkg::*; #(
  parameter  int TILELEN  = 64,
  parameter  int BEATSMP  = 2,
  parameter  int FFTCHNL  = 8,
  parameter  int CMPLXLEN = 32,
  localparam int WBEATS   = TILELEN / BEATSMP,
  localparam int RBEATS   = TILELEN / FFTCHNL,
  localparam int WW       = cnt_w(WBEATS),
  localparam int RW       = cnt_w(RBEATS)
) (
  input  logic                               clk,
  input  logic                               rstn,
  input  logic                               clr,
  input  logic                               wr_en,
  input  logic [WW-1:0]                      wr_beat,
  input  logic [BEATSMP-1:0][CMPLXLEN-1:0]   wr_data,
  input  logic [RW-1:0]                      rd_beat,
  output logic [FFTCHNL-1:0][CMPLXLEN-1:0]   rd_data
);

  logic [TILELEN-1:0][CMPLXLEN-1:0]         mem_q, mem_d;
  logic [RBEATS-1:0][FFTCHNL*CMPLXLEN-1:0]  rd_view;

  // Each position knows statically which beat and lane can write it.
  for (genvar p = 0; p < TILELEN; p++) begin : g_pos
    assign mem_d[p] = clr ? '0 :
                      (wr_en && wr_beat == WW'(p / BEATSMP)) ? wr_data[p % BEATSMP] :
                      mem_q[p];
  end

  always_ff @(posedge clk) begin
    if (!rstn) mem_q <= '0;
    else       mem_q <= mem_d;
  end

  assign rd_view = mem_q;
  assign rd_data = rd_view[rd_beat];

endmodule

// File: rtl/fft_tile_loader.sv
// Loads an AXI-stream packet tile-major into PARATIL tile buffers, then drains FFTCHNL lanes of every tile per beat.
// Optional FFT_TILE_PKTCHK_EN: pkt_err pulses when inlast and buffer-full do not coincide.
module fft_tile_loader import fft_ctrl_pkg::*; #(
  parameter int PARATIL = 9,
  parameter int FFTCHNL = 8,
  parameter int DATALEN = 16,
  parameter int TILELEN = 64,
  parameter int AXIWID  = 64
) (
  input  logic                                  clk,
  input  logic                                  rstn,
  input  logic                                  axi_invalid,
  output logic                                  axi_inready,
  input  logic                                  axi_inlast,
  input  logic [AXIWID-1:0]                     axi_indata,
  output logic                                  fftvalid,
  input  logic                                  fftready,
  output logic                                  fftlast,
  output logic [PARATIL*FFTCHNL*2*DATALEN-1:0]  fftdata,
  output logic                                  busy,
  output logic                                  pkt_err
);

  localparam int CMPLXLEN = cmplx_len(DATALEN);
  localparam int BEATSMP  = beat_smp(AXIWID, DATALEN);
  localparam int WBEATS   = TILELEN / BEATSMP;
  localparam int RBEATS   = TILELEN / FFTCHNL;
  localparam int TW       = cnt_w(PARATIL);
  localparam int WW       = cnt_w(WBEATS);
  localparam int RW       = cnt_w(RBEATS);

  state_e          state_q, state_d;
  logic [TW-1:0]   tile_q, tile_d;
  logic [WW-1:0]   wbeat_q, wbeat_d;
  logic [RW-1:0]   rbeat_q, rbeat_d;
  logic            in_fire, out_fire, buf_full, load_done, drain_done, clr;
  logic [PARATIL-1:0][FFTCHNL*CMPLXLEN-1:0] rd_data;

  assign in_fire    = axi_invalid && axi_inready;
  assign out_fire   = fftvalid && fftready;
  assign buf_full   = (tile_q == TW'(PARATIL - 1)) && (wbeat_q == WW'(WBEATS - 1));
  assign load_done  = in_fire && (axi_inlast || buf_full);
  assign drain_done = out_fire && fftlast;

  // State register
  always_ff @(posedge clk) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state; a one-beat packet skips LOAD entirely
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_fire)    state_d = load_done ? DRAIN : LOAD;
      LOAD:    if (load_done)  state_d = DRAIN;
      DRAIN:   if (drain_done) state_d = IDLE;
      default:                 state_d = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    axi_inready = (state_q != DRAIN);
    busy        = (state_q != IDLE);
    fftvalid    = (state_q == DRAIN);
    fftlast     = fftvalid && (rbeat_q == RW'(RBEATS - 1));
    clr         = drain_done;
  end

  always_comb begin
    tile_d  = tile_q;
    wbeat_d = wbeat_q;
    rbeat_d = rbeat_q;
    if (in_fire) begin
      if (wbeat_q == WW'(WBEATS - 1)) begin
        wbeat_d = '0;
        tile_d  = tile_q + TW'(1);
      end else begin
        wbeat_d = wbeat_q + WW'(1);
      end
    end
    if (load_done) begin
      tile_d  = '0;
      wbeat_d = '0;
    end
    if (out_fire) rbeat_d = fftlast ? '0 : rbeat_q + RW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      tile_q  <= '0;
      wbeat_q <= '0;
      rbeat_q <= '0;
    end else begin
      tile_q  <= tile_d;
      wbeat_q <= wbeat_d;
      rbeat_q <= rbeat_d;
    end
  end

`ifdef FFT_TILE_PKTCHK_EN
  logic err_q, err_d;

  // Error when the packet ends short, or the buffer fills before inlast shows up
  always_comb err_d = load_done && (axi_inlast != buf_full);

  always_ff @(posedge clk) begin
    if (!rstn) err_q <= 1'b0;
    else       err_q <= err_d;
  end

  assign pkt_err = err_q;
`else
  assign pkt_err = 1'b0;
`endif

  for (genvar t = 0; t < PARATIL; t++) begin : g_tile
    fft_tile_buf #(
      .TILELEN  (TILELEN),
      .BEATSMP  (BEATSMP),
      .FFTCHNL  (FFTCHNL),
      .CMPLXLEN (CMPLXLEN)
    ) u_buf (
      .clk     (clk),
      .rstn    (rstn),
      .clr     (clr),
      .wr_en   (in_fire && (tile_q == TW'(t))),
      .wr_beat (wbeat_q),
      .wr_data (axi_indata),
      .rd_beat (rbeat_q),
      .rd_data (rd_data[t])
    );
  end

  // Zero outside DRAIN so nothing stale is visible while loading
  assign fftdata = fftvalid ? rd_data : '0;

endmodule

// File: tb/tb_fft_tile_loader.sv
// Directed bench for fft_tile_loader: packet table plus reset, back-to-back and parameter-sweep sequences.
module tb_fft_tile_loader;

  localparam int P   = 9, F = 8, T = 64, B = 2, CL = 32;
  localparam int RB  = T / F;
  localparam int NS  = P * T;
  localparam int DW  = P * F * CL;
  localparam int P2  = 2, F2 = 4, T2 = 16, B2 = 4;
  localparam int DW2 = P2 * F2 * CL;

  logic              clk = 1'b0, rstn = 1'b0;
  logic              invalid = 1'b0, inlast = 1'b0, inready;
  logic [63:0]       indata = '0;
  logic              fvalid, fready = 1'b1, flast, busy, perr;
  logic [DW-1:0]     fdata;

  logic              invalid2 = 1'b0, inlast2 = 1'b0, inready2;
  logic [127:0]      indata2 = '0;
  logic              fvalid2, fready2 = 1'b1, flast2, busy2, perr2;
  logic [DW2-1:0]    fdata2;

  fft_tile_loader u_dut (
    .clk(clk), .rstn(rstn),
    .axi_invalid(invalid), .axi_inready(inready), .axi_inlast(inlast), .axi_indata(indata),
    .fftvalid(fvalid), .fftready(fready), .fftlast(flast), .fftdata(fdata),
    .busy(busy), .pkt_err(perr)
  );

  fft_tile_loader #(.PARATIL(P2), .FFTCHNL(F2), .DATALEN(16), .TILELEN(T2), .AXIWID(128)) u_dut2 (
    .clk(clk), .rstn(rstn),
    .axi_invalid(invalid2), .axi_inready(inready2), .axi_inlast(inlast2), .axi_indata(indata2),
    .fftvalid(fvalid2), .fftready(fready2), .fftlast(flast2), .fftdata(fdata2),
    .busy(busy2), .pkt_err(perr2)
  );

  always #5 clk = ~clk;

  typedef struct {
    int    nbeats;
    bit    last;
    bit    bp;
    bit    gaps;
    int    exp_err;
    int    exp_obeats;
    string nm;
  } vec_t;

  vec_t  tv[5];
  int    nchk = 0, nerr = 0;
  string cur = "reset";
  int    ok2 = 0, bi2 = 0;

  function automatic logic [31:0] smp(input int pid, input int n);
    logic [15:0] re, im;
    re = 16'(n);
    im = 16'(pid * 257) ^ 16'h5A5A ^ 16'(n * 3);
    return {re, im};
  endfunction

  function automatic logic [DW-1:0] exp1(input int pid, input int nsamp, input int k);
    logic [DW-1:0] v;
    int n;
    v = '0;
    for (int t = 0; t < P; t++)
      for (int c = 0; c < F; c++) begin
        n = t * T + k * F + c;
        if (n < nsamp) v[(t*F+c)*CL +: CL] = smp(pid, n);
      end
    return v;
  endfunction

  function automatic logic [DW2-1:0] exp2(input int pid, input int k);
    logic [DW2-1:0] v;
    v = '0;
    for (int t = 0; t < P2; t++)
      for (int c = 0; c < F2; c++)
        v[(t*F2+c)*CL +: CL] = smp(pid, t * T2 + k * F2 + c);
    return v;
  endfunction

  task automatic chk_int(input string nm, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s/%s got=%0h exp=%0h", cur, nm, got, exp);
    end
  endtask

  task automatic chk_vec(input string nm, input int k, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    bit done;
    nchk++;
    if (got !== exp) begin
      nerr++;
      done = 0;
      for (int i = 0; i < DW / CL; i++)
        if (!done && got[i*CL +: CL] !== exp[i*CL +: CL]) begin
          $display("FAIL %s/%s beat %0d sample slot %0d got=%h exp=%h", cur, nm, k, i,
                   got[i*CL +: CL], exp[i*CL +: CL]);
          done = 1;
        end
    end
  endtask

  task automatic run_pkt(input vec_t v, input int pid);
    int bi, ok, cyc, nsamp, errs, experr;
    bit prev_stall;
    bi = 0; ok = 0; cyc = 0; errs = 0; prev_stall = 0;
    cur = v.nm;
    nsamp = (v.nbeats * B > NS) ? NS : v.nbeats * B;
`ifdef FFT_TILE_PKTCHK_EN
    experr = v.exp_err;
`else
    experr = 0;
`endif
    while (ok < v.exp_obeats && cyc < 4000) begin
      if (bi < v.nbeats && !(v.gaps && (cyc % 7 == 3))) begin
        invalid = 1'b1;
        indata  = {smp(pid, 2*bi+1), smp(pid, 2*bi)};
        inlast  = v.last && (bi == v.nbeats - 1);
      end else begin
        // Garbage with inlast high must be ignored while invalid is low
        invalid = 1'b0;
        indata  = {$urandom, $urandom};
        inlast  = 1'b1;
      end
      fready = v.bp ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
      @(negedge clk);
      if (perr) errs++;
      if (bi == 0 && invalid) chk_int("first_ready", 32'(inready), 1);
      if (prev_stall) chk_int("hold_valid", 32'(fvalid), 1);
      if (fvalid) begin
        chk_vec("data", ok, fdata, exp1(pid, nsamp, ok));
        chk_int("last", 32'(flast), 32'(ok == RB - 1));
        chk_int("inready_drain", 32'(inready), 0);
      end
      prev_stall = fvalid && !fready;
      if (invalid && inready) bi++;
      if (fvalid && fready) ok++;
      cyc++;
      @(posedge clk); #1;
    end
    invalid = 1'b0;
    inlast  = 1'b0;
    if (ok < v.exp_obeats) begin
      nchk++; nerr++;
      $display("FAIL %s/timeout out_beats got=%0d exp=%0d", cur, ok, v.exp_obeats);
    end
    chk_int("beats_in", bi, v.nbeats);
    chk_int("pkt_err_pulses", errs, experr);
    chk_int("idle_valid", 32'(fvalid), 0);
    chk_int("idle_busy", 32'(busy), 0);
  endtask

  initial begin
    tv[0] = '{nbeats: 288, last: 1, bp: 0, gaps: 0, exp_err: 0, exp_obeats: RB, nm: "full"};
    tv[1] = '{nbeats: 40,  last: 1, bp: 0, gaps: 0, exp_err: 1, exp_obeats: RB, nm: "short"};
    tv[2] = '{nbeats: 288, last: 0, bp: 0, gaps: 0, exp_err: 1, exp_obeats: RB, nm: "fill_no_last"};
    tv[3] = '{nbeats: 288, last: 1, bp: 1, gaps: 1, exp_err: 0, exp_obeats: RB, nm: "backpressure"};
    tv[4] = '{nbeats: 1,   last: 1, bp: 0, gaps: 0, exp_err: 1, exp_obeats: RB, nm: "one_beat"};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk_int("busy", 32'(busy), 0);
    chk_int("fftvalid", 32'(fvalid), 0);
    chk_int("fftlast", 32'(flast), 0);
    chk_int("pkt_err", 32'(perr), 0);
    chk_int("inready", 32'(inready), 1);
    chk_vec("fftdata", 0, fdata, '0);
    chk_int("busy2", 32'(busy2), 0);
    rstn = 1'b1;

    // Back-to-back packets; short after full exposes any residue
    for (int i = 0; i < 5; i++) run_pkt(tv[i], i + 1);

    // Reset in the middle of LOAD
    cur = "mid_reset";
    for (int i = 0; i < 100; i++) begin
      invalid = 1'b1;
      indata  = {smp(8, 2*i+1), smp(8, 2*i)};
      inlast  = 1'b0;
      @(posedge clk); #1;
    end
    chk_int("busy_loading", 32'(busy), 1);
    rstn    = 1'b0;
    invalid = 1'b0;
    @(posedge clk); #1;
    chk_int("busy", 32'(busy), 0);
    chk_int("fftvalid", 32'(fvalid), 0);
    chk_vec("fftdata", 0, fdata, '0);
    rstn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_int("no_emit", 32'(fvalid), 0);
      @(posedge clk); #1;
    end
    run_pkt(tv[0], 9);

    // Parameter sweep instance: 8 beats in, 4 beats out
    cur = "sweep";
    for (int cyc = 0; cyc < 100 && ok2 < 4; cyc++) begin
      if (bi2 < 8) begin
        invalid2 = 1'b1;
        indata2  = {smp(7, 4*bi2+3), smp(7, 4*bi2+2), smp(7, 4*bi2+1), smp(7, 4*bi2)};
        inlast2  = (bi2 == 7);
      end else begin
        invalid2 = 1'b0;
        inlast2  = 1'b0;
      end
      @(negedge clk);
      if (fvalid2) begin
        chk_vec("data", ok2, DW'(fdata2), DW'(exp2(7, ok2)));
        chk_int("last", 32'(flast2), 32'(ok2 == 3));
      end
      if (invalid2 && inready2) bi2++;
      if (fvalid2 && fready2) ok2++;
      @(posedge clk); #1;
    end
    invalid2 = 1'b0;
    if (ok2 < 4) begin
      nchk++; nerr++;
      $display("FAIL sweep/timeout out_beats got=%0d exp=4", ok2);
    end
    chk_int("beats_in", bi2, 8);
    chk_int("idle_valid", 32'(fvalid2), 0);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule

// File: doc/fft_tile_loader.md
FFT_TILE_LOADER -- requirements
Module: fft_tile_loader

Interface
REQ-001 SHALL have parameter PARATIL, default 9: number of tiles buffered and emitted in parallel.
REQ-002 SHALL have parameter FFTCHNL, default 8: complex samples per tile per output beat.
REQ-003 SHALL have parameter DATALEN, default 16: bits per real/imag part; complex sample CMPLXLEN = 2*DATALEN.
REQ-004 SHALL have parameter TILELEN, default 64: complex samples per tile; multiple of FFTCHNL and of BEATSMP.
REQ-005 SHALL have parameter AXIWID, default 64: input beat width; BEATSMP = AXIWID/CMPLXLEN samples per beat.
REQ-006 SHALL have port clk  input  1: single clock, all logic on rising edge.
REQ-007 SHALL have port rstn  input  1: synchronous active-low reset.
REQ-008 SHALL have ports axi_invalid/axi_inready  input/output  1 each: input handshake; transfer when both high.
REQ-009 SHALL have port axi_inlast  input  1: last beat of packet.
REQ-010 SHALL have port axi_indata  input  AXIWID: BEATSMP samples, lane 0 in LSBs, lane 0 is earliest sample.
REQ-011 SHALL have ports fftvalid/fftready  output/input  1 each: output handshake.
REQ-012 SHALL have port fftlast  output  1: marks final beat of a drain.
REQ-013 SHALL have port fftdata  output  PARATIL*FFTCHNL*CMPLXLEN: tile t at slice t, sample lane c within tile at sub-slice c.
REQ-014 SHALL have port busy  output  1: high in any state other than IDLE.
REQ-015 SHALL have port pkt_err  output  1: one-cycle length-error pulse (see Configuration).

Function
REQ-016 SHALL implement states IDLE, LOAD, DRAIN.
REQ-017 SHALL, in IDLE and LOAD, hold axi_inready high; in DRAIN, hold it low.
REQ-018 SHALL, on the first accepted beat in IDLE, enter LOAD and write it as samples 0..BEATSMP-1 of tile 0.
REQ-019 SHALL write input samples tile-major: sample index n maps to tile n/TILELEN, position n%TILELEN.
REQ-020 SHALL leave LOAD for DRAIN on the beat carrying axi_inlast or on the beat filling PARATIL*TILELEN samples, whichever comes first.
REQ-021 SHALL treat unwritten positions of a short packet as zero; the buffer is zeroed on DRAIN exit.
REQ-022 SHALL assert fftvalid the cycle after LOAD exits; beat k (0..TILELEN/FFTCHNL-1) carries positions k*FFTCHNL..k*FFTCHNL+FFTCHNL-1 of every tile, lowest position in lane 0.
REQ-023 SHALL hold fftdata, fftlast and fftvalid stable while fftvalid and not fftready.
REQ-024 SHALL assert fftlast with beat TILELEN/FFTCHNL-1; on its acceptance return to IDLE with fftvalid low next cycle.
REQ-025 SHALL accept a new packet's first beat the cycle after return to IDLE (no input while DRAIN).
REQ-026 SHALL ignore axi_indata and axi_inlast when axi_invalid is low.

Reset
REQ-027 SHALL, on rstn low at a clock edge, force IDLE, fftvalid=0, fftlast=0, pkt_err=0, busy=0, all counters 0, buffer zeroed, fftdata=0.
REQ-028 SHALL discard any partial load or drain when reset occurs mid-operation; no beat emitted after reset until a new packet.

Configuration
REQ-029 SHALL, with FFT_TILE_PKTCHK_EN defined, pulse pkt_err one cycle after LOAD exit if inlast arrived before the buffer was full, or the buffer filled on a beat without inlast.
REQ-030 SHALL, without FFT_TILE_PKTCHK_EN, tie pkt_err to 0 with all other behaviour identical.

Structure
REQ-031 SHALL place the state enum and CMPLXLEN/BEATSMP derivation helpers in shared package fft_ctrl_pkg.
REQ-032 SHALL instantiate PARATIL copies of sub-module fft_tile_buf (one tile: BEATSMP-lane write port, FFTCHNL-lane read port, synchronous clear).

Verification
REQ-033 Full packet, defaults: 288 beats, inlast on 288th -> 8 output beats, beat 0 tile 0 lane 0 = input sample 0, tile 8 lane 7 of beat 7 = sample 575, fftlast on beat 7, pkt_err 0.
REQ-034 Short packet: 40 beats with inlast -> tile 0 positions 0..63 and tile 1 positions 0..15 data, all else zero; pkt_err pulses once when PKTCHK enabled.
REQ-035 Backpressure: fftready toggled 1,0,0,1 repeating -> every beat held stable while stalled, 8 beats accepted, axi_inready low throughout DRAIN.
REQ-036 Reset asserted mid-LOAD at beat 100 -> IDLE next cycle, fftvalid 0; subsequent full packet drains identical to REQ-033.
REQ-037 Back-to-back packets with constant fftready=1 -> second packet's first beat accepted the cycle after fftlast acceptance, second drain carries no residue of first.
REQ-038 Parameter sweep PARATIL=2, FFTCHNL=4, TILELEN=16, AXIWID=128 -> 8 input beats, 4 output beats, sample order per REQ-019/REQ-022.
